// File: rtl/i2c_eeprom_slave.sv
// I2C target modelling a 256-byte serial EEPROM with an auto-incrementing address pointer.
// SCL/SDA are oversampled on the system clock; all bus events are decoded from synchronized edges.
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR  = 7'b1010000,
  parameter int         MEM_DEPTH = 256
) (
  input  logic       i_clk10MHz,
  input  logic       i_RST,
  input  logic       i_SCL,
  input  logic       i_SDA,
  output logic       o_SDA_Drive_Low,
  output logic [7:0] o_Current_Addr,
  output logic       o_Busy,
  output logic       o_Wr_Strobe
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_REG_ADDR,
    S_REG_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  scl_q, sda_q;
  logic        scl_s, scl_d, sda_s, sda_d;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic        drive, drive_nx;
  logic        rw, rw_nx;
  logic [7:0]  addr, addr_nx, addr_inc;
  logic [7:0]  shift, shift_nx, rx_byte;
  logic [3:0]  cnt, cnt_nx;
  logic        mem_we, strobe_nx;
  logic [7:0]  mem [0:MEM_DEPTH-1];

  // Synchronizers preset high so reset release never looks like a START or STOP.
  always_ff @(posedge i_clk10MHz) begin
    if (i_RST) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], i_SCL};
      sda_q <= {sda_q[1:0], i_SDA};
    end
  end

  assign scl_s     = scl_q[1];
  assign scl_d     = scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_d     = sda_q[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & ~sda_s & sda_d;
  assign stop_det  = scl_s & scl_d & sda_s & ~sda_d;
  assign rx_byte   = {shift[6:0], sda_s};
  assign addr_inc  = addr + 8'd1;

  always_ff @(posedge i_clk10MHz) begin
    if (i_RST) begin
      state       <= S_IDLE;
      drive       <= 1'b0;
      rw          <= 1'b0;
      addr        <= 8'h00;
      shift       <= 8'h00;
      cnt         <= 4'd0;
      o_Wr_Strobe <= 1'b0;
    end else begin
      state       <= state_nx;
      drive       <= drive_nx;
      rw          <= rw_nx;
      addr        <= addr_nx;
      shift       <= shift_nx;
      cnt         <= cnt_nx;
      o_Wr_Strobe <= strobe_nx;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge i_clk10MHz) begin
    if (!i_RST && mem_we) mem[addr] <= rx_byte;
  end

  // ACK states: the fall after bit 8 pulls SDA low, the 9th rise advances; the following
  // fall is handled by the next state (release when receiving, first data bit when reading).
  always_comb begin
    state_nx  = state;
    drive_nx  = drive;
    rw_nx     = rw;
    addr_nx   = addr;
    shift_nx  = shift;
    cnt_nx    = cnt;
    mem_we    = 1'b0;
    strobe_nx = 1'b0;
    if (start_det) begin
      state_nx = S_DEV_ADDR;
      cnt_nx   = 4'd0;
      drive_nx = 1'b0;
    end else if (stop_det) begin
      state_nx = S_IDLE;
      drive_nx = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_WAIT_STOP: drive_nx = 1'b0;
        S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
          if (scl_fall) drive_nx = 1'b0;
          if (scl_rise) begin
            shift_nx = rx_byte;
            cnt_nx   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_nx = 4'd0;
              if (state == S_DEV_ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'd0) begin
                  rw_nx    = rx_byte[0];
                  state_nx = S_DEV_ACK;
                end else begin
                  state_nx = S_IDLE;
                end
              end else if (state == S_REG_ADDR) begin
                addr_nx  = rx_byte;
                state_nx = S_REG_ACK;
              end else begin
                mem_we    = 1'b1;
                strobe_nx = 1'b1;
                addr_nx   = addr_inc;
                state_nx  = S_WR_ACK;
              end
            end
          end
        end
        S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            drive_nx = 1'b1;
          end else if (scl_rise) begin
            cnt_nx = 4'd0;
            if (state == S_DEV_ACK && rw) begin
              shift_nx = mem[addr];
              state_nx = S_RD_DATA;
            end else if (state == S_DEV_ACK) begin
              state_nx = S_REG_ADDR;
            end else begin
              state_nx = S_WR_DATA;
            end
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              drive_nx = 1'b0;
              cnt_nx   = 4'd0;
              state_nx = S_RD_ACK;
            end else begin
              drive_nx = ~shift[7];
              shift_nx = {shift[6:0], 1'b1};
              cnt_nx   = cnt + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            addr_nx = addr_inc;
            if (!sda_s) begin
              shift_nx = mem[addr_inc];
              cnt_nx   = 4'd0;
              state_nx = S_RD_DATA;
            end else begin
              state_nx = S_WAIT_STOP;
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
          drive_nx = 1'b0;
        end
      endcase
    end
  end

  assign o_SDA_Drive_Low = drive;
  assign o_Current_Addr  = addr;
  assign o_Busy          = (state != S_IDLE);

endmodule

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
- Synthesizable I2C target that models a 256-byte serial EEPROM.
- Serves as the far end for the I2C EEPROM master in board-level benches and FPGA loopback builds.
- Oversamples SCL/SDA on the 10 MHz system clock, decodes START/STOP, matches the device address, and ACKs.
- Accepts the register-address byte, then performs sequential writes or sequential reads with an auto-incrementing internal address pointer.

Parameters:
- DEV_ADDR, 7'b1010000, 7-bit device address the block responds to.
- MEM_DEPTH, 256, number of bytes; fixed to 2^8, matching the 8-bit register address.

Ports:
- i_clk10MHz  in  1  system clock; all logic on its rising edge.
- i_RST  in  1  synchronous reset, active-high.
- i_SCL  in  1  I2C clock from the bus, asynchronous.
- i_SDA  in  1  I2C data from the bus (resolved wire value), asynchronous.
- o_SDA_Drive_Low  out  1  1 = pull SDA low (open-drain enable); 0 = release.
- o_Current_Addr  out  8  internal address pointer.
- o_Busy  out  1  1 while a transaction addressed to this device is in progress.
- o_Wr_Strobe  out  1  one-cycle pulse when a data byte is committed to memory.

Behaviour:
- Reset (i_RST=1 at a clock edge):
  - state=IDLE, o_SDA_Drive_Low=0, o_Current_Addr=0, o_Busy=0, o_Wr_Strobe=0.
  - Synchronizers preset to 1 so that no false START/STOP is detected after reset.
  - Memory contents are NOT reset.
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer plus a third flop for edge detection.
  - An event is recognised 3 clocks after the pin changes.
- Bus events:
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
  - Data is sampled on SCL rise. o_SDA_Drive_Low changes only on SCL fall, or on STOP/START.
- Priority:
  - START and STOP override every state.
  - START (including repeated START) → DEV_ADDR with bit count cleared and SDA released.
  - STOP → IDLE, SDA released.
- States:
  - IDLE: o_Busy=0; wait for START.
  - DEV_ADDR: shift in 8 bits, MSB first. After the 8th rise:
    - Upper 7 bits == DEV_ADDR → DEV_ACK.
    - Otherwise → IDLE; never drive SDA again until the next START.
  - DEV_ACK:
    - Drive low from the SCL fall after bit 8 to the SCL fall after bit 9.
    - R/W=0 → REG_ADDR.
    - R/W=1 → load mem[o_Current_Addr] into the shift register → RD_DATA.
  - REG_ADDR: shift in 8 bits; at the 8th rise, o_Current_Addr ← byte; → REG_ACK.
  - REG_ACK: ACK as in DEV_ACK; → WR_DATA.
  - WR_DATA: shift in 8 bits; at the 8th rise:
    - mem[o_Current_Addr] ← byte; o_Wr_Strobe pulses one clock; o_Current_Addr ← o_Current_Addr+1.
    - → WR_ACK.
  - WR_ACK: ACK; → WR_DATA.
  - RD_DATA:
    - On each SCL fall, drive low iff the current MSB of the shift register is 0; then shift.
    - After the 8th bit, release SDA on the next fall → RD_ACK.
  - RD_ACK: sample SDA on the 9th rise.
    - 0 (master ACK): o_Current_Addr+1, reload the shift register from the new address, → RD_DATA.
    - 1 (NACK): o_Current_Addr+1, → WAIT_STOP with SDA released.
  - WAIT_STOP: ignore bits until START/STOP.
- o_Busy=1 in every state except IDLE and an unmatched-address wait.
- Address pointer:
  - 8-bit modulo arithmetic; 8'hFF+1 wraps to 8'h00 for both reads and writes.
  - Retained across STOP, so a current-address read continues from the last access +1.
  - A random read (write device address, register address, repeated START, read device address) reads from the loaded address.
- A STOP inside a partially received data byte discards that byte; no write and no increment.
- Reset asserted mid-transfer: immediate return to the reset values on that clock edge; SDA released within one clock.
- General call (address 0) is not supported: treated as a mismatch.

Test Plan:
- Reset, idle bus with SCL=SDA=1 → o_SDA_Drive_Low=0, o_Busy=0, o_Current_Addr=8'h00, and no START detected.
- Write with START, 0xA0, 0x10, 0x55, 0xAA, STOP → ACK on each of 4 bytes; mem[0x10]=0x55, mem[0x11]=0xAA; two o_Wr_Strobe pulses; o_Current_Addr=0x12.
- Random read with START, 0xA0, 0x10, repeated START, 0xA1, read 2 bytes (master ACK then NACK), STOP → SDA carries 0x55 then 0xAA MSB first; o_Current_Addr=0x12; SDA released after NACK.
- Wrap: write 0x11, 0x22 starting at reg 0xFF, then read 2 bytes from 0xFF → mem[0xFF]=0x11, mem[0x00]=0x22; pointer reads back 0x01 after the read.
- Address mismatch: START, 0xA2, 0x10, 0x77, STOP → o_SDA_Drive_Low stays 0 throughout (NACK); memory unchanged; o_Busy=0.
- Abort cases:
  - STOP after 4 bits of a data byte → no o_Wr_Strobe; pointer unchanged.
  - i_RST pulsed while driving a read 0 → o_SDA_Drive_Low=0 the next clock; state IDLE; o_Current_Addr=0.
